i2c_request_arbiter: RTL and testbench



---
 rtl/i2c_arb_pkg.sv | 42 ++++
 rtl/i2c_request_arbiter_rr_picker.sv | 41 ++++
 rtl/i2c_request_arbiter.sv | 144 ++++++++++++++
 tb/tb_i2c_request_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C request arbiter and the engine wrapper.
// Holds FSM states, the latched command bundle and control-word bit map.
package i2c_arb_pkg;

  localparam int IDX_W = 3;
  localparam int CNT_W = 21;

  localparam int CTL_RW_BIT      = 0;
  localparam int CTL_CNT_LSB     = 1;
  localparam int CTL_USE_REG_BIT = 5;
  localparam int CTL_START_BIT   = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } arb_state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] reg_addr;
    logic [3:0] byte_count;
    logic       read_write;
    logic       use_register;
  } i2c_cmd_t;

  function automatic logic [31:0] ctl_word(
    input i2c_cmd_t c,
    input logic     start
  );
    logic [31:0] w;
    w = '0;
    w[CTL_RW_BIT]         = c.read_write;
    w[CTL_CNT_LSB +: 4]   = c.byte_count;
    w[CTL_USE_REG_BIT]    = c.use_register;
    w[CTL_START_BIT]      = start;
    return w;
  endfunction

endpackage

// File: rtl/i2c_request_arbiter_rr_picker.sv
// Round-robin one-hot picker: first set req bit above ptr, with wrap.
// Ports: req, ptr in; gnt_onehot, gnt_idx, any out.
module rr_picker
  import i2c_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [N-1:0] rot;
  logic [3:0]   sh;
  int           off;
  int           sum;

  // Rotate so bit 0 is the requester just after ptr.
  always_comb begin
    sh  = 4'(ptr) + 4'd1;
    rot = N'({req, req} >> sh);
    off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    any = |req;
    sum = int'(ptr) + 1 + off;
    if (sum >= N) sum = sum - N;
    gnt_idx = any ? IDX_W'(sum) : '0;
  end

  always_comb begin
    gnt_onehot = '0;
    for (int k = 0; k < N; k++) begin
      gnt_onehot[k] = any && (gnt_idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Shares one I2C master engine among NUM_REQ requesters, round-robin.
// Ports: req_* in / req_ready, rsp_* out; eng_* engine side; grant_id.
module i2c_request_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [4*NUM_REQ-1:0] req_byte_count,
  input  logic [NUM_REQ-1:0]   req_read_write,
  input  logic [NUM_REQ-1:0]   req_use_register,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_ack_error,
  output logic                 rsp_timeout,
  output logic                 rsp_bad_cmd,
  output logic [31:0]          eng_address,
  output logic [31:0]          eng_register,
  output logic [31:0]          eng_control,
  input  logic                 eng_start_ack,
  input  logic                 eng_busy,
  input  logic                 eng_ack_error,
  output logic                 eng_abort,
  output logic [IDX_W-1:0]     grant_id
);

  arb_state_t         state_q, state_d;
  i2c_cmd_t           cmd_q, sel;
  logic [IDX_W-1:0]   rr_ptr_q, grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ack_err_q, tmo_q, bad_q;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any;
  logic               active, tmo_hit, take, start;

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel.addr         = req_addr[i*7 +: 7];
        sel.reg_addr     = req_reg[i*8 +: 8];
        sel.byte_count   = req_byte_count[i*4 +: 4];
        sel.read_write   = req_read_write[i];
        sel.use_register = req_use_register[i];
      end
    end
  end

  assign take    = (state_q == IDLE) && any;
  assign active  = (state_q == ISSUE) || (state_q == WAIT_BUSY) ||
                   (state_q == WAIT_DONE);
  assign tmo_hit = active &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_clk) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Timeout wins over start_ack and busy fall in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = (sel.byte_count == 4'd0) ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_hit)            state_d = RESPOND;
        else if (eng_start_ack) state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tmo_hit)       state_d = RESPOND;
        else if (eng_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tmo_hit || !eng_busy) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start     = (state_q == ISSUE);
    req_ready = (state_q == IDLE && !axi_reset) ? gnt_oh : '0;
    rsp_valid = '0;
    if (state_q == RESPOND) begin
      rsp_valid = NUM_REQ'(1) << grant_q;
    end
    eng_abort = tmo_hit && !axi_reset;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      cmd_q     <= '0;
      rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      ack_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      if (take) begin
        cmd_q     <= sel;
        rr_ptr_q  <= gnt_idx;
        grant_q   <= gnt_idx;
        cnt_q     <= '0;
        ack_err_q <= 1'b0;
        tmo_q     <= 1'b0;
        bad_q     <= (sel.byte_count == 4'd0);
      end
      if (active) cnt_q <= cnt_q + 1'b1;
      if (state_q == WAIT_DONE && !eng_busy && !tmo_hit) begin
        ack_err_q <= eng_ack_error;
      end
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign eng_address   = {25'b0, cmd_q.addr};
  assign eng_register  = {24'b0, cmd_q.reg_addr};
  assign eng_control   = ctl_word(cmd_q, start);
  assign rsp_ack_error = ack_err_q;
  assign rsp_timeout   = tmo_q;
  assign rsp_bad_cmd   = bad_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Randomized bench for i2c_request_arbiter against a transaction model.
// Model: round-robin pick, engine timing and timeout at cycle level.
module tb_i2c_request_arbiter;

  localparam int N   = 4;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           axi_reset;
  logic [N-1:0]   req_valid, req_ready, req_rw, req_use, rsp_valid;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_reg;
  logic [4*N-1:0] req_bc;
  logic           rsp_ack_error, rsp_timeout, rsp_bad_cmd;
  logic [31:0]    eng_address, eng_register, eng_control;
  logic           eng_start_ack, eng_busy, eng_ack_error, eng_abort;
  logic [2:0]     grant_id;

  int total = 0;
  int bad   = 0;
  int m_ptr = N - 1;

  i2c_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .axi_clk          (clk),
    .axi_reset        (axi_reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_reg          (req_reg),
    .req_byte_count   (req_bc),
    .req_read_write   (req_rw),
    .req_use_register (req_use),
    .rsp_valid        (rsp_valid),
    .rsp_ack_error    (rsp_ack_error),
    .rsp_timeout      (rsp_timeout),
    .rsp_bad_cmd      (rsp_bad_cmd),
    .eng_address      (eng_address),
    .eng_register     (eng_register),
    .eng_control      (eng_control),
    .eng_start_ack    (eng_start_ack),
    .eng_busy         (eng_busy),
    .eng_ack_error    (eng_ack_error),
    .eng_abort        (eng_abort),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int i = 1; i <= N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic set_cmd(int i, logic [6:0] a, logic [7:0] r,
                         logic [3:0] bc, logic rw, logic use_r);
    req_addr[i*7 +: 7] = a;
    req_reg[i*8 +: 8]  = r;
    req_bc[i*4 +: 4]   = bc;
    req_rw[i]          = rw;
    req_use[i]         = use_r;
  endtask

  task automatic rand_cmd(int i);
    set_cmd(i, 7'($urandom), 8'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [9:0] obs_v();
    return {req_ready, rsp_valid, eng_control[7], eng_abort};
  endfunction

  task automatic do_reset();
    axi_reset = 1'b1;
    req_valid = '0;
    eng_start_ack = 0; eng_busy = 0; eng_ack_error = 0;
    next();
    next();
    axi_reset = 1'b0;
    m_ptr = N - 1;
  endtask

  // Called in an IDLE cycle with req_valid already driven.
  task automatic do_txn(int ack_dly, int gap, int busy_len,
                        bit aerr, bit keep, int rst_k, bit churn);
    int g, ack_k, fall_k, end_k;
    logic [6:0] a;
    logic [7:0] r;
    logic [3:0] bc;
    logic rw, ur;
    logic [31:0] ctl;
    logic [N-1:0] rsp_e;
    g = pick(req_valid, m_ptr);
    chk("has_req", 64'(g >= 0), 64'd1);
    if (g < 0) return;
    a  = req_addr[g*7 +: 7];
    r  = req_reg[g*8 +: 8];
    bc = req_bc[g*4 +: 4];
    rw = req_rw[g];
    ur = req_use[g];
    ctl = {23'b0, 1'b0, 1'b0, 1'b0, ur, bc, rw};
    #2;
    chk("ready", 64'(obs_v()), 64'({oh(g), {N{1'b0}}, 2'b00}));
    next();
    m_ptr = g;
    if (!keep) begin
      req_valid[g] = 1'b0;
      rand_cmd(g);
    end
    if (bc == 4'd0) begin
      #2;
      chk("bad_rsp", 64'(obs_v()), 64'({{N{1'b0}}, oh(g), 2'b00}));
      chk("bad_flags", {rsp_ack_error, rsp_timeout, rsp_bad_cmd}, 3'b001);
      chk("bad_ctl", eng_control, ctl);
      next();
      return;
    end
    ack_k  = 1 + ack_dly;
    fall_k = ack_k + gap + busy_len;
    end_k  = (fall_k < TMO) ? fall_k : TMO;
    for (int k = 1; k <= end_k + 1; k++) begin
      eng_start_ack = (k == ack_k);
      eng_busy      = (k >= ack_k + gap) && (k < fall_k);
      eng_ack_error = (k == fall_k) && aerr;
      if (k == rst_k) axi_reset = 1'b1;
      if (churn && k == 2) req_valid = req_valid | N'($urandom);
      #2;
      if (k == 1) begin
        chk("addr", eng_address, {25'b0, a});
        chk("reg", eng_register, {24'b0, r});
        chk("ctl", eng_control, ctl | 32'h80);
        chk("gid", grant_id, g);
      end
      rsp_e = (k == end_k + 1) ? oh(g) : '0;
      chk("cycle", 64'(obs_v()),
          64'({{N{1'b0}}, rsp_e, 1'(k <= ack_k && k <= end_k),
               1'(k == end_k && fall_k >= TMO)}));
      if (k == end_k + 1) begin
        chk("flags", {rsp_ack_error, rsp_timeout, rsp_bad_cmd},
            {1'(aerr && fall_k < TMO), 1'(fall_k >= TMO), 1'b0});
      end
      if (k == rst_k) begin
        next();
        axi_reset = 1'b0;
        eng_start_ack = 0; eng_busy = 0; eng_ack_error = 0;
        req_valid = '0;
        #2;
        chk("post_rst", {req_ready, rsp_valid, eng_abort, grant_id,
                         rsp_ack_error, rsp_timeout, rsp_bad_cmd},
            '0);
        chk("post_rst_eng", {eng_control, eng_address}, '0);
        m_ptr = N - 1;
        next();
        return;
      end
      next();
    end
    eng_start_ack = 0; eng_busy = 0; eng_ack_error = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int ad, gp, bl;
    req_valid = '0;
    eng_start_ack = 0; eng_busy = 0; eng_ack_error = 0;
    for (int i = 0; i < N; i++) rand_cmd(i);
    do_reset();
    #2;
    chk("rst_ctl", eng_control, 0);
    chk("rst_addr_reg", {eng_address, eng_register}, 0);
    chk("rst_misc", {grant_id, rsp_ack_error, rsp_timeout, rsp_bad_cmd}, 0);
    chk("rst_obs", 64'(obs_v()), 0);
    next();

    // requester 1 alone, 3-cycle ack, 40-cycle busy
    set_cmd(1, 7'h48, 8'h10, 4'd2, 1'b0, 1'b1);
    req_valid = 4'b0010;
    do_txn(3, 1, 40, 0, 0, 0, 0);
    chk("t1_gid", grant_id, 1);
    chk("t1_flags", {rsp_ack_error, rsp_timeout, rsp_bad_cmd}, 0);

    // fairness from reset
    do_reset();
    for (int i = 0; i < N; i++)
      set_cmd(i, 7'($urandom), 8'($urandom), 4'($urandom_range(1, 15)),
              1'($urandom), 1'($urandom));
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      do_txn($urandom_range(0, 4), $urandom_range(0, 1),
             $urandom_range(2, 20), 0, 1, 0, 0);
      chk("rr_order", grant_id, i % N);
    end

    // NACK reported
    req_valid = '0;
    set_cmd(3, 7'h22, 8'h05, 4'd5, 1'b1, 1'b1);
    req_valid = 4'b1000;
    do_txn(1, 0, 10, 1, 0, 0, 0);
    chk("aerr", {rsp_ack_error, rsp_timeout}, 2'b10);

    // engine hangs, then next request served normally
    set_cmd(0, 7'h11, 8'h22, 4'd3, 1'b0, 1'b0);
    req_valid = 4'b0001;
    do_txn(2, 1, 100000, 0, 0, 0, 0);
    chk("tmo", rsp_timeout, 1);
    set_cmd(1, 7'h12, 8'h34, 4'd4, 1'b1, 1'b0);
    req_valid = 4'b0010;
    do_txn(2, 1, 12, 0, 0, 0, 0);
    chk("tmo_clear", rsp_timeout, 0);

    // busy fall one cycle before and exactly at the timeout
    set_cmd(2, 7'h33, 8'h44, 4'd1, 1'b0, 1'b1);
    req_valid = 4'b0100;
    do_txn(2, 0, 96, 1, 0, 0, 0);
    set_cmd(3, 7'h35, 8'h46, 4'd6, 1'b0, 1'b1);
    req_valid = 4'b1000;
    do_txn(2, 0, 97, 1, 0, 0, 0);

    // zero byte count on requester 2
    set_cmd(2, 7'h40, 8'h01, 4'd0, 1'b1, 1'b1);
    req_valid = 4'b0100;
    do_txn(0, 0, 2, 0, 0, 0, 0);

    // reset in WAIT_DONE, then requester 0 wins first
    set_cmd(3, 7'h50, 8'h60, 4'd7, 1'b0, 1'b1);
    req_valid = 4'b1000;
    do_txn(1, 1, 30, 0, 0, 10, 0);
    for (int i = 0; i < N; i++) rand_cmd(i);
    req_valid = '1;
    do_txn(1, 0, 5, 0, 0, 0, 0);
    chk("rst_first", grant_id, 0);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      req_valid = (req_valid | N'($urandom)) & N'($urandom | $urandom);
      if (req_valid == '0) req_valid[$urandom_range(0, N - 1)] = 1'b1;
      ad = $urandom_range(0, 5);
      gp = $urandom_range(0, 1);
      bl = $urandom_range(2, 30);
      if ($urandom_range(0, 7) == 0) bl = 100 - 1 - ad - gp + $urandom_range(0, 1) - 1 + 1;
      if ($urandom_range(0, 15) == 0) bl = 5000;
      do_txn(ad, gp, bl, 1'($urandom), 1'($urandom), 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
